// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared constants and state type for the flip responder
package sb_pkg;

    // Monitor status encoding
    localparam logic [1:0] ST_NORMAL = 2'b00;
    localparam logic [1:0] ST_LOW    = 2'b01;
    localparam logic [1:0] ST_HIGH   = 2'b10;
    localparam logic [1:0] ST_CRIT   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FLIP,
        S_COOLDOWN,
        S_FAULT
    } flip_state_t;

    localparam int DEF_DEBOUNCE  = 3;
    localparam int DEF_COOLDOWN  = 4;
    localparam int DEF_MAX_RETRY = 2;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/flip_debounce.sv
// rtl/flip_debounce.sv - small up-counter with clear, load-to-one and terminal flag
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr        : force count to zero
//   load       : start a new run with count = 1
//   en         : advance the count; holds once the terminal value is reached
//   done       : count equals TERM
module flip_debounce #(
    parameter int W    = 2,
    parameter int TERM = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam logic [W-1:0] TERM_V = W'(TERM);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (load) begin
            count <= W'(1);
        end else if (en && !done) begin
            count <= count + W'(1);
        end
    end

    assign done = (count == TERM_V);

endmodule

// File: rtl/flip_ctrl.sv
// rtl/flip_ctrl.sv - debounced flip responder with cooldown, retry limit and sticky fault
//
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   need_flip   : flip request from the temperature monitor
//   status      : monitor status; critical bypasses the debounce
//   flip        : registered one-cycle flip pulse
//   busy        : high while debouncing, flipping or cooling down
//   fault       : sticky, set after the retry budget is exhausted
//   flip_count  : total flips issued, saturating
module flip_ctrl
    import sb_pkg::*;
#(
    parameter int DEBOUNCE  = DEF_DEBOUNCE,
    parameter int COOLDOWN  = DEF_COOLDOWN,
    parameter int MAX_RETRY = DEF_MAX_RETRY,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             need_flip,
    input  logic [1:0]       status,
    output logic             flip,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] flip_count
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int CW = $clog2(COOLDOWN + 1);
    // +2 keeps the retry counter at least one bit wide when MAX_RETRY is 0
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_MAX_V = RW'(MAX_RETRY);

    flip_state_t state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic flip_d, busy_d, fault_d;

    logic deb_clr, deb_load, deb_en, deb_done;
    logic cd_clr, cd_load, cd_en, cd_done;

    // Debounce run: loaded to 1 on the first high sample, terminal at DEBOUNCE-1
    // so the flip lands on the DEBOUNCE-th consecutive high sample.
    flip_debounce #(
        .W    (DW),
        .TERM (DEBOUNCE - 1)
    ) u_deb (
        .clk   (clk),
        .reset (reset),
        .clr   (deb_clr),
        .load  (deb_load),
        .en    (deb_en),
        .done  (deb_done)
    );

    // Cooldown run: loaded to 1 when leaving FLIP; the decision edge is the one
    // that sees the count already at COOLDOWN.
    flip_debounce #(
        .W    (CW),
        .TERM (COOLDOWN)
    ) u_cd (
        .clk   (clk),
        .reset (reset),
        .clr   (cd_clr),
        .load  (cd_load),
        .en    (cd_en),
        .done  (cd_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        deb_clr  = 1'b0;
        deb_load = 1'b0;
        deb_en   = 1'b0;
        cd_clr   = 1'b0;
        cd_load  = 1'b0;
        cd_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (need_flip) begin
                    if (status == ST_CRIT || DEBOUNCE == 1) begin
                        state_d = S_FLIP;
                    end else begin
                        state_d  = S_WAIT;
                        deb_load = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!need_flip) begin
                    state_d = S_IDLE;
                    deb_clr = 1'b1;
                end else if (status == ST_CRIT || deb_done) begin
                    state_d = S_FLIP;
                    deb_clr = 1'b1;
                end else begin
                    deb_en = 1'b1;
                end
            end
            S_FLIP: begin
                state_d = S_COOLDOWN;
                cd_load = 1'b1;
            end
            S_COOLDOWN: begin
                if (!cd_done) begin
                    cd_en = 1'b1;
                end else begin
                    cd_clr = 1'b1;
                    if (!need_flip) begin
                        state_d = S_IDLE;
                        retry_d = '0;
                    end else if (retry_q < RETRY_MAX_V) begin
                        // Request still present: retry immediately, no debounce
                        state_d = S_FLIP;
                        retry_d = retry_q + RW'(1);
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of the state being entered
        flip_d  = (state_d == S_FLIP);
        busy_d  = (state_d == S_WAIT) || (state_d == S_FLIP) || (state_d == S_COOLDOWN);
        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flip       <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            flip_count <= '0;
            retry_q    <= '0;
        end else begin
            flip    <= flip_d;
            busy    <= busy_d;
            fault   <= fault_d;
            retry_q <= retry_d;
            if (flip_d && (flip_count != {CNT_W{1'b1}})) begin
                flip_count <= flip_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_flip_ctrl.sv
// tb/tb_flip_ctrl.sv - self-checking bench for flip_ctrl
module tb_flip_ctrl;

    localparam int DEB  = 3;
    localparam int CD   = 4;
    localparam int MAXR = 2;
    localparam int CW   = 8;

    logic          clk;
    logic          reset;
    logic          need_flip;
    logic [1:0]    status;
    logic          flip;
    logic          busy;
    logic          fault;
    logic [CW-1:0] flip_count;

    flip_ctrl #(
        .DEBOUNCE  (DEB),
        .COOLDOWN  (CD),
        .MAX_RETRY (MAXR),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .need_flip  (need_flip),
        .status     (status),
        .flip       (flip),
        .busy       (busy),
        .fault      (fault),
        .flip_count (flip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: counts consecutive high samples while idle, and
    // edges elapsed since the last flip while a flip burst is in progress.
    int streak   = 0;
    int since    = 0;
    int retries  = 0;
    bit in_burst = 0;
    bit m_flip   = 0;
    bit m_busy   = 0;
    bit m_fault  = 0;
    int m_count  = 0;

    int e = 0;
    int flip_h  [0:63];
    int busy_h  [0:63];
    int fault_h [0:63];
    int count_h [0:63];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_flip();
        m_flip   = 1;
        m_busy   = 1;
        in_burst = 1;
        since    = 0;
        streak   = 0;
        if (m_count < (1 << CW) - 1) m_count++;
    endtask

    task automatic model_edge(input bit rst, input bit nf, input logic [1:0] st);
        if (rst) begin
            streak = 0; since = 0; retries = 0; in_burst = 0;
            m_flip = 0; m_busy = 0; m_fault = 0; m_count = 0;
        end else if (m_fault) begin
            m_flip = 0;
            m_busy = 0;
        end else if (in_burst) begin
            since++;
            m_flip = 0;
            m_busy = 1;
            if (since == CD + 1) begin
                if (!nf) begin
                    in_burst = 0;
                    retries  = 0;
                    m_busy   = 0;
                end else if (retries < MAXR) begin
                    retries++;
                    do_flip();
                end else begin
                    in_burst = 0;
                    m_fault  = 1;
                    m_busy   = 0;
                end
            end
        end else if (nf) begin
            streak++;
            if (st == 2'b11 || streak >= DEB) begin
                do_flip();
            end else begin
                m_flip = 0;
                m_busy = 1;
            end
        end else begin
            streak = 0;
            m_flip = 0;
            m_busy = 0;
        end
    endtask

    task automatic clear_hist();
        e = 0;
        for (int i = 0; i < 64; i++) begin
            flip_h[i] = 0; busy_h[i] = 0; fault_h[i] = 0; count_h[i] = 0;
        end
    endtask

    task automatic step(input bit rst, input bit nf, input logic [1:0] st);
        reset     = rst;
        need_flip = nf;
        status    = st;
        @(posedge clk);
        model_edge(rst, nf, st);
        #1;
        check("flip", int'(flip), int'(m_flip));
        check("busy", int'(busy), int'(m_busy));
        check("fault", int'(fault), int'(m_fault));
        check("flip_count", int'(flip_count), m_count);
        if (e < 64) begin
            flip_h[e]  = int'(flip);
            busy_h[e]  = int'(busy);
            fault_h[e] = int'(fault);
            count_h[e] = int'(flip_count);
        end
        e++;
    endtask

    task automatic steps(input int n, input bit nf, input logic [1:0] st);
        for (int i = 0; i < n; i++) step(1'b0, nf, st);
    endtask

    int nflips;

    initial begin
        reset     = 1'b1;
        need_flip = 1'b0;
        status    = 2'b00;

        // 1: reset then idle
        step(1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        clear_hist();
        steps(3, 1'b0, 2'b00);
        check("t1_flip", flip_h[2], 0);
        check("t1_busy", busy_h[2], 0);
        check("t1_fault", fault_h[2], 0);
        check("t1_count", count_h[2], 0);

        // 2: debounced flip then cooldown to idle
        clear_hist();
        steps(6, 1'b1, 2'b10);
        steps(4, 1'b0, 2'b10);
        check("t2_busy_e0", busy_h[0], 1);
        check("t2_flip_e1", flip_h[1], 0);
        check("t2_flip_e2", flip_h[2], 1);
        check("t2_flip_e3", flip_h[3], 0);
        check("t2_busy_e6", busy_h[6], 1);
        check("t2_busy_e7", busy_h[7], 0);
        check("t2_count", count_h[9], 1);

        // 3: glitch shorter than the debounce
        step(1'b1, 1'b0, 2'b00);
        clear_hist();
        steps(2, 1'b1, 2'b01);
        steps(2, 1'b0, 2'b01);
        check("t3_busy_e1", busy_h[1], 1);
        check("t3_busy_e2", busy_h[2], 0);
        check("t3_flip_e1", flip_h[1], 0);
        check("t3_count", count_h[3], 0);

        // 4: critical status bypasses debounce
        step(1'b1, 1'b0, 2'b00);
        clear_hist();
        step(1'b0, 1'b1, 2'b11);
        steps(6, 1'b0, 2'b00);
        check("t4_flip_e0", flip_h[0], 1);
        check("t4_flip_e1", flip_h[1], 0);
        check("t4_count", count_h[6], 1);

        // 5: stuck request exhausts retries
        step(1'b1, 1'b0, 2'b00);
        clear_hist();
        steps(22, 1'b1, 2'b10);
        nflips = 0;
        for (int i = 0; i < 22; i++) nflips += flip_h[i];
        check("t5_nflips", nflips, 3);
        check("t5_flip_e2", flip_h[2], 1);
        check("t5_flip_e7", flip_h[7], 1);
        check("t5_flip_e12", flip_h[12], 1);
        check("t5_fault_e16", fault_h[16], 0);
        check("t5_fault_e17", fault_h[17], 1);
        check("t5_busy_e17", busy_h[17], 0);
        check("t5_count", count_h[21], 3);
        step(1'b1, 1'b1, 2'b10);
        check("t5_reset_fault", int'(fault), 0);
        check("t5_reset_count", int'(flip_count), 0);

        // 6: reset mid-cooldown, then a fresh full debounce
        step(1'b1, 1'b0, 2'b00);
        clear_hist();
        steps(4, 1'b1, 2'b10);
        step(1'b1, 1'b1, 2'b10);
        step(1'b0, 1'b0, 2'b10);
        check("t6_busy_e3", busy_h[3], 1);
        check("t6_busy_e5", busy_h[5], 0);
        check("t6_flip_e5", flip_h[5], 0);
        check("t6_count_e5", count_h[5], 0);
        clear_hist();
        steps(6, 1'b1, 2'b10);
        check("t6_flip_e1", flip_h[1], 0);
        check("t6_flip_e2", flip_h[2], 1);
        check("t6_count", count_h[5], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
